// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and response signals of the ALU issue stage.
// master = sequencer, slave = surrounding pipeline (producer, ALU, consumer).
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic [3:0]            cmd_fun;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [3:0]            alu_fun;
  logic                  alu_go;
  logic [DATA_WIDTH-1:0] alu_out;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [3:0]            rsp_fun;

  logic [LVL_W-1:0]      fifo_level;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, alu_out, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fun, alu_go,
           rsp_valid, rsp_data, rsp_fun, fifo_level
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, alu_out, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fun, alu_go,
           rsp_valid, rsp_data, rsp_fun, fifo_level
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and issues one at a time; result returns ALU_LATENCY+1 cycles after issue.
// CMD side stalls only when the FIFO is full; a stalled response blocks further issue.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1
) (
  input logic               clk,
  input logic               rst,
  alu_cmd_sequencer_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int LAT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [3:0]            fun;
  } cmd_t;

  cmd_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic [LAT_W-1:0] lat_cnt;
  logic [1:0]       state;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic rsp_fire;
  logic start_issue;

  assign full        = (count == LVL_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign push        = bus.cmd_valid && !full;
  assign pop         = (state == S_ISSUE);
  assign rsp_fire    = bus.rsp_valid && bus.rsp_ready;
  // ALU operands are loaded one cycle early so they are already valid during ISSUE.
  assign start_issue = !empty && ((state == S_IDLE) || ((state == S_RESP) && rsp_fire));

  assign bus.cmd_ready  = !full;
  assign bus.fifo_level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_fun};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_fun   <= '0;
      bus.alu_go    <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_fun   <= '0;
    end else begin
      bus.alu_go <= start_issue;
      if (start_issue) begin
        bus.alu_a   <= mem[rd_ptr].a;
        bus.alu_b   <= mem[rd_ptr].b;
        bus.alu_fun <= mem[rd_ptr].fun;
      end
      case (state)
        S_IDLE: begin
          if (!empty) state <= S_ISSUE;
        end
        S_ISSUE: begin
          lat_cnt <= LAT_W'(ALU_LATENCY);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            bus.rsp_data  <= bus.alu_out;
            bus.rsp_fun   <= bus.alu_fun;
            bus.rsp_valid <= 1'b1;
            state         <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            bus.rsp_valid <= 1'b0;
            state         <= empty ? S_IDLE : S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a 1-cycle ALU build and a 3-cycle ALU build.
module tb_alu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cyc = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          go_cnt = 0;
  logic [19:0] rsp_q[$];
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  alu_cmd_sequencer_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) bus1 ();
  alu_cmd_sequencer_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) bus3 ();

  alu_cmd_sequencer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  alu_cmd_sequencer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] fun);
    case (fun[3:2])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Stubs: combinational ALU for the 1-cycle build, time-varying output for the 3-cycle build.
  assign bus1.alu_out = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_fun);
  assign bus3.alu_out = bus3.alu_a + cyc;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus1.rsp_valid && bus1.rsp_ready) rsp_q.push_back({bus1.rsp_fun, bus1.rsp_data});
      if (bus1.alu_go) go_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                       input string tag);
    int k = 0;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_a     = a;
    bus1.cmd_b     = b;
    bus1.cmd_fun   = f;
    while (!bus1.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check(tag, 32'(bus1.cmd_ready), 32'd1);
    tick();
    bus1.cmd_valid = 1'b0;
    exp_q.push_back({f, alu_model(a, b, f)});
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int k = 0;
    while (rsp_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic cmp_rsp(input int n, input string tag);
    logic [19:0] got;
    logic [19:0] exp;
    for (int i = 0; i < n; i++) begin
      if (rsp_q.size() > 0 && exp_q.size() > 0) begin
        got = rsp_q.pop_front();
        exp = exp_q.pop_front();
        check(tag, 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_alu_a"},   32'(bus1.alu_a),      32'd0);
    check({tag, "_alu_b"},   32'(bus1.alu_b),      32'd0);
    check({tag, "_alu_fun"}, 32'(bus1.alu_fun),    32'd0);
    check({tag, "_alu_go"},  32'(bus1.alu_go),     32'd0);
    check({tag, "_rsp_vld"}, 32'(bus1.rsp_valid),  32'd0);
    check({tag, "_rsp_dat"}, 32'(bus1.rsp_data),   32'd0);
    check({tag, "_rsp_fun"}, 32'(bus1.rsp_fun),    32'd0);
    check({tag, "_level"},   32'(bus1.fifo_level), 32'd0);
    check({tag, "_cmd_rdy"}, 32'(bus1.cmd_ready),  32'd1);
  endtask

  initial begin
    int          n;
    int          qs;
    int          g0;
    bit          go_seen;
    logic [15:0] d0;
    logic [3:0]  f0;
    logic [15:0] c0;

    bus1.cmd_valid = 1'b0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_fun = '0;
    bus1.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_a = '0; bus3.cmd_b = '0; bus3.cmd_fun = '0;
    bus3.rsp_ready = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("rst");

    // Single add: response 4 cycles after the push cycle.
    bus1.rsp_ready = 1'b1;
    push1(16'h0005, 16'h0003, 4'b0000, "add_push");
    check("add_level", 32'(bus1.fifo_level), 32'd1);
    n = 0;
    go_seen = 1'b0;
    while (!bus1.rsp_valid && n < 10) begin
      tick();
      n++;
      if (bus1.alu_go) begin
        go_seen = 1'b1;
        check("add_alu_a", 32'(bus1.alu_a), 32'h5);
        check("add_alu_b", 32'(bus1.alu_b), 32'h3);
      end
    end
    check("add_go_seen", 32'(go_seen), 32'd1);
    check("add_latency", 32'(n + 1), 32'd4);
    check("add_rsp_data", 32'(bus1.rsp_data), 32'h8);
    check("add_rsp_fun", 32'(bus1.rsp_fun), 32'h0);
    tick();
    check("add_rsp_drop", 32'(bus1.rsp_valid), 32'd0);
    rsp_q.delete();
    exp_q.delete();

    // Fill: first command parks in RESP, next four fill the FIFO, sixth is held off.
    bus1.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push1(16'h0040 + 16'(i), 16'h0010 * 16'(i + 1), 4'(i * 5), "fill_push");
    check("fill_level", 32'(bus1.fifo_level), 32'd4);
    check("fill_cmd_rdy", 32'(bus1.cmd_ready), 32'd0);
    check("fill_parked", 32'(bus1.rsp_valid), 32'd1);
    g0 = go_cnt;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_a = 16'h0777; bus1.cmd_b = 16'h0123; bus1.cmd_fun = 4'hE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold_rdy", 32'(bus1.cmd_ready), 32'd0);
      check("full_hold_level", 32'(bus1.fifo_level), 32'd4);
    end
    check("full_no_go", 32'(go_cnt), 32'(g0));
    bus1.rsp_ready = 1'b1;
    push1(16'h0777, 16'h0123, 4'hE, "full_sixth");
    wait_q(6, 100, "fill_rsp_count");
    cmp_rsp(6, "fill_order");

    // Wrap: ten commands streamed through, function code rolling past 15.
    for (int i = 0; i < 10; i++)
      push1(16'h1000 + 16'h0111 * 16'(i), 16'(i), 4'((i + 10) & 15), "wrap_push");
    wait_q(10, 200, "wrap_rsp_count");
    cmp_rsp(10, "wrap_order");
    repeat (3) tick();
    check("wrap_level", 32'(bus1.fifo_level), 32'd0);

    // Response backpressure with a second command queued behind it.
    rsp_q.delete();
    exp_q.delete();
    bus1.rsp_ready = 1'b0;
    push1(16'hABCD, 16'h00FF, 4'b1001, "bp_push");
    n = 0;
    while (!bus1.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_rsp_vld", 32'(bus1.rsp_valid), 32'd1);
    d0 = bus1.rsp_data;
    f0 = bus1.rsp_fun;
    check("bp_rsp_data", 32'(d0), 32'(alu_model(16'hABCD, 16'h00FF, 4'b1001)));
    g0 = go_cnt;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus1.rsp_ready = 1'b1;
      check("bp_stable_vld", 32'(bus1.rsp_valid), 32'd1);
      check("bp_stable_data", 32'(bus1.rsp_data), 32'(d0));
      check("bp_stable_fun", 32'(bus1.rsp_fun), 32'(f0));
      if (k == 0) begin
        push1(16'h0002, 16'h0001, 4'b0100, "bp_push2");
      end else begin
        qs = rsp_q.size();
        tick();
      end
    end
    check("bp_single", 32'(rsp_q.size()), 32'd1);
    check("bp_no_go", 32'(go_cnt), 32'(g0));
    check("bp_drop", 32'(bus1.rsp_valid), 32'd0);
    wait_q(2, 20, "bp_rsp_count");
    cmp_rsp(2, "bp_order");

    // Reset while the first of three commands is in WAIT.
    rsp_q.delete();
    exp_q.delete();
    push1(16'h0011, 16'h0022, 4'h0, "mid_push");
    push1(16'h0033, 16'h0044, 4'h1, "mid_push");
    push1(16'h0055, 16'h0066, 4'h2, "mid_push");
    check("mid_level", 32'(bus1.fifo_level), 32'd2);
    qs = rsp_q.size();
    g0 = go_cnt;
    rst = 1'b1;
    tick();
    check_reset_state("mid_rst");
    rst = 1'b0;
    repeat (12) tick();
    check("mid_no_rsp", 32'(rsp_q.size()), 32'(qs));
    check("mid_no_go", 32'(go_cnt), 32'(g0));
    exp_q.delete();

    // 3-cycle ALU build: operands stable across issue and wait, result sampled at t+3.
    bus3.rsp_ready = 1'b1;
    bus3.cmd_valid = 1'b1;
    bus3.cmd_a = 16'h0100; bus3.cmd_b = 16'h0002; bus3.cmd_fun = 4'hB;
    check("l3_cmd_rdy", 32'(bus3.cmd_ready), 32'd1);
    tick();
    bus3.cmd_valid = 1'b0;
    n = 0;
    while (!bus3.alu_go && n < 10) begin
      tick();
      n++;
    end
    check("l3_go", 32'(bus3.alu_go), 32'd1);
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      check("l3_alu_a", 32'(bus3.alu_a), 32'h0100);
      check("l3_alu_b", 32'(bus3.alu_b), 32'h0002);
      check("l3_alu_fun", 32'(bus3.alu_fun), 32'hB);
      tick();
    end
    check("l3_rsp_timing", 32'(bus3.rsp_valid), 32'd1);
    check("l3_rsp_data", 32'(bus3.rsp_data), 32'(16'h0100 + c0 + 16'd3));
    check("l3_rsp_fun", 32'(bus3.rsp_fun), 32'hB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Issue stage directly upstream of the ALU decoder and functional units. It buffers operation requests (A, B, ALU_FUN) in a small command FIFO and presents one command at a time to the ALU datapath. ALU_FUN[3:2] drives the unit decoder and ALU_FUN[1:0] selects the operation inside the unit. It waits the fixed ALU latency, captures the muxed ALU result and returns it on a valid/ready response port.

Parameters:
DATA_WIDTH, 16, operand/result width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
ALU_LATENCY, 1, cycles from ALU_GO to a valid ALU_OUT (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
CMD_VALID  in  1  command request
CMD_READY  out  1  FIFO can accept a command
CMD_A  in  DATA_WIDTH  operand A
CMD_B  in  DATA_WIDTH  operand B
CMD_FUN  in  4  function code ([3:2] unit, [1:0] op)
ALU_A  out  DATA_WIDTH  operand A to ALU
ALU_B  out  DATA_WIDTH  operand B to ALU
ALU_FUN  out  4  function code to decoder/units
ALU_GO  out  1  one-cycle strobe; ALU inputs valid this cycle
ALU_OUT  in  DATA_WIDTH  muxed ALU result
RSP_VALID  out  1  response available
RSP_READY  in  1  consumer accepts response
RSP_DATA  out  DATA_WIDTH  captured result
RSP_FUN  out  4  function code of the response
FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Reset (RST=1 at a rising edge): FIFO flushed; FSM to IDLE. All outputs 0: ALU_A, ALU_B, ALU_FUN, ALU_GO, RSP_VALID, RSP_DATA, RSP_FUN, FIFO_LEVEL. CMD_READY=1 from the first cycle after reset. Reset mid-operation discards the in-flight command and any pending response. The response is not produced later.
- FIFO: CMD_READY = !full, derived from registered state. Push when CMD_VALID&&CMD_READY. Pop only in ISSUE.
  - Push while full is not accepted, even if a pop occurs the same cycle.
  - Push and pop in the same cycle when not full: FIFO_LEVEL unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH. First-in, first-out order is preserved across the wrap.
- FSM states:
  - IDLE: if FIFO not empty, go to ISSUE next cycle; else stay.
  - ISSUE (1 cycle):
    - ALU_GO=1.
    - ALU_A/ALU_B/ALU_FUN = FIFO head, registered so they are valid in this cycle. The bench sees them with ALU_GO.
    - Pop head. Load latency counter with ALU_LATENCY. Go to WAIT.
  - WAIT: lasts exactly ALU_LATENCY cycles. ALU_A/B/FUN held stable. ALU_GO=0. On the last WAIT cycle, capture ALU_OUT into RSP_DATA and ALU_FUN into RSP_FUN. Go to RESP.
  - RESP:
    - RSP_VALID=1; RSP_DATA and RSP_FUN held stable until the handshake.
    - On RSP_VALID&&RSP_READY, drop RSP_VALID next cycle.
    - Next state is ISSUE if the FIFO is non-empty at that edge, else IDLE.
- Latency: ISSUE at cycle t, ALU_OUT sampled at end of cycle t+ALU_LATENCY, RSP_VALID high from t+ALU_LATENCY+1.
  - Minimum accept-to-response latency with empty FIFO and RSP_READY=1: push at t0, IDLE sees non-empty at t0+1, ISSUE at t0+2, RSP_VALID at t0+3+ALU_LATENCY.
  - Back-to-back throughput: one command per ALU_LATENCY+2 cycles.
- Backpressure: while in RESP with RSP_READY=0, no new issue occurs. The FIFO keeps accepting until full.
- ALU_FUN is passed unmodified. All 16 codes are legal; the sequencer does not interpret them.

Test Plan:
- Single add: after reset, push A=16'h0005, B=16'h0003, FUN=4'b0000. The ALU stub returns A+B after 1 cycle. Required: ALU_GO pulse with ALU_A=5, ALU_B=3; then RSP_VALID with RSP_DATA=16'h0008, RSP_FUN=0. RSP_VALID rises 4 cycles after the accepting edge.
- Fill/full: hold RSP_READY=0 and push 6 commands back-to-back. Required:
  - first issued and parked in RESP; next 4 fill the FIFO, FIFO_LEVEL=4, CMD_READY=0;
  - 6th not accepted until RSP_READY=1;
  - responses then return in push order.
- Wrap order: stream 10 commands with B=index and FUN cycling 0..15, RSP_READY=1. Required: 10 responses, RSP_FUN and data in exact push order across pointer wrap, FIFO_LEVEL returns to 0.
- Response backpressure: response pending, RSP_READY low 5 cycles then high. Required: RSP_DATA/RSP_FUN stable for all 6 cycles, single handshake, no ALU_GO during the stall.
- Reset mid-operation: assert RST during WAIT with 2 commands queued. Required: next cycle all outputs 0, FIFO_LEVEL=0, CMD_READY=1; no response ever emitted for the flushed commands.
- ALU_LATENCY=3 build: push one command. Required: ALU_A/B/FUN stable for 4 cycles from ALU_GO; RSP_DATA equals the stub's value at cycle t+3.
